cnu_sched: RTL and testbench

Iteration scheduler for a single shared check-node unit (CNU) in the LDPC decoder. It walks the parity-check rows of the code, one row per cycle, and issues a read of each row's variable-to-check messages. It then tracks each row through the fixed CNU pipeline latency and issues the matching write-back of check-to-variable messages. It repeats whole iterations until the iteration limit is reached or, optionally, the syndrome is satisfied.

---
 rtl/ldpc_pkg.sv | 16 +
 rtl/cnu_sched_if.sv | 32 +++
 rtl/cnu_lat_track.sv | 40 ++++
 rtl/cnu_sched.sv | 164 ++++++++++++++++
 tb/tb_cnu_sched.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder types: scheduler states and default widths
// used by the CNU, message memories and the row scheduler.
package ldpc_pkg;

  localparam int ROW_W  = 3;
  localparam int ITER_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/cnu_sched_if.sv
// Control/status bundle between the decoder controller (master)
// and the CNU row scheduler (slave).
interface cnu_sched_if #(
  parameter int ROW_W  = ldpc_pkg::ROW_W,
  parameter int ITER_W = ldpc_pkg::ITER_W
);

  logic              start;
  logic [ITER_W-1:0] max_iter;
  logic              row_parity;
  logic              busy;
  logic              rd_en;
  logic [ROW_W-1:0]  rd_row;
  logic              wr_en;
  logic [ROW_W-1:0]  wr_row;
  logic [ITER_W-1:0] iter;
  logic              done;
  logic              converged;

  modport master (
    output start, max_iter, row_parity,
    input  busy, rd_en, rd_row, wr_en, wr_row,
    input  iter, done, converged
  );

  modport slave (
    input  start, max_iter, row_parity,
    output busy, rd_en, rd_row, wr_en, wr_row,
    output iter, done, converged
  );

endinterface

// File: rtl/cnu_lat_track.sv
// {valid,row} delay line matching the CNU pipeline depth.
// o_empty: nothing in flight behind the output stage.
module cnu_lat_track #(
  parameter int LAT = 4,
  parameter int RW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [RW-1:0] i_row,
  output logic          o_vld,
  output logic [RW-1:0] o_row,
  output logic          o_empty
);

  localparam logic [LAT-1:0] PEND =
    ~(LAT'(1) << (LAT - 1));

  logic [LAT-1:0]         r_vld;
  logic [LAT-1:0][RW-1:0] r_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_row <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_row[0] <= i_row;
      for (int i = LAT - 1; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1];
        r_row[i] <= r_row[i-1];
      end
    end
  end

  assign o_vld   = r_vld[LAT-1];
  assign o_row   = r_row[LAT-1];
  assign o_empty = ~|(r_vld & PEND);

endmodule

// File: rtl/cnu_sched.sv
// Row/iteration scheduler for one shared CNU.
// Build option: LDPC_EARLY_TERM_EN (stop on zero syndrome).
module cnu_sched #(
  parameter int M       = 8,
  parameter int ROW_W   = ldpc_pkg::ROW_W,
  parameter int CNU_LAT = 4,
  parameter int ITER_W  = ldpc_pkg::ITER_W
) (
  input logic        clk,
  input logic        rst,
  cnu_sched_if.slave bus
);

  import ldpc_pkg::*;

  localparam logic [ROW_W-1:0] LAST = ROW_W'(M - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ROW_W-1:0]  r_rd_row;
  logic [ROW_W-1:0]  w_row_nxt;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;
  logic [ITER_W-1:0] r_iter;
  logic [ITER_W-1:0] w_iter_nxt;
  logic [ITER_W-1:0] w_iter_inc;
  logic [ITER_W-1:0] r_max;
  logic [ITER_W-1:0] w_max_nxt;
  logic              w_synd_clr;
  logic              w_early;
  logic              w_wr_en;
  logic [ROW_W-1:0]  w_wr_row;
  logic              w_trk_empty;

  cnu_lat_track #(
    .LAT (CNU_LAT),
    .RW  (ROW_W)
  ) u_trk (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (r_rd_en),
    .i_row   (r_rd_row),
    .o_vld   (w_wr_en),
    .o_row   (w_wr_row),
    .o_empty (w_trk_empty)
  );

`ifdef LDPC_EARLY_TERM_EN
  logic r_synd;
  logic r_conv;
  logic w_conv_nxt;

  assign w_early = ~r_synd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_synd <= 1'b0;
      r_conv <= 1'b0;
    end else begin
      r_conv <= w_conv_nxt;
      r_synd <= w_synd_clr ? 1'b0
              : r_synd | (w_wr_en & bus.row_parity);
    end
  end

  assign bus.converged = r_conv;
`else
  logic w_unused;

  assign w_early       = 1'b0;
  assign w_unused      = ^{bus.row_parity, w_synd_clr};
  assign bus.converged = 1'b0;
`endif

  assign w_iter_inc = (&r_iter) ? r_iter
                    : r_iter + ITER_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_rd_row;
    w_iter_nxt  = r_iter;
    w_max_nxt   = r_max;
    w_synd_clr  = 1'b0;
`ifdef LDPC_EARLY_TERM_EN
    w_conv_nxt  = r_conv;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = ISSUE;
          w_row_nxt   = '0;
          w_iter_nxt  = '0;
          w_max_nxt   = (bus.max_iter == '0) ? ITER_W'(1)
                      : bus.max_iter;
          w_synd_clr  = 1'b1;
`ifdef LDPC_EARLY_TERM_EN
          w_conv_nxt  = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (r_rd_row == LAST) begin
          w_state_nxt = DRAIN;
        end else begin
          w_row_nxt = r_rd_row + ROW_W'(1);
        end
      end
      DRAIN: begin
        if (w_trk_empty) begin
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        w_iter_nxt = w_iter_inc;
        if (w_iter_inc == r_max || w_early) begin
          w_state_nxt = DONE;
`ifdef LDPC_EARLY_TERM_EN
          w_conv_nxt  = ~r_synd;
`endif
        end else begin
          w_state_nxt = ISSUE;
          w_row_nxt   = '0;
          w_synd_clr  = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rd_row <= '0;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_iter   <= '0;
      r_max    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_row <= w_row_nxt;
      r_rd_en  <= (w_state_nxt == ISSUE);
      r_busy   <= (w_state_nxt != IDLE);
      r_done   <= (w_state_nxt == DONE);
      r_iter   <= w_iter_nxt;
      r_max    <= w_max_nxt;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.rd_en  = r_rd_en;
  assign bus.rd_row = r_rd_row;
  assign bus.wr_en  = w_wr_en;
  assign bus.wr_row = w_wr_row;
  assign bus.iter   = r_iter;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_cnu_sched.sv
// Directed bench for cnu_sched (M=8, CNU_LAT=4); cycle c is the
// period following the c-th edge counted from the start edge.
module tb_cnu_sched;

  import ldpc_pkg::*;

  localparam int M   = 8;
  localparam int LAT = 4;
  localparam int NC  = 128;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cnu_sched_if #(.ROW_W(ROW_W), .ITER_W(ITER_W)) bus ();

  cnu_sched #(
    .M       (M),
    .ROW_W   (ROW_W),
    .CNU_LAT (LAT),
    .ITER_W  (ITER_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int c;
    int rd_en;
    int rd_row;
    int wr_en;
    int wr_row;
    int busy;
    int done;
    int iter;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic a_rd_en [NC];
  logic [31:0] a_rd_row [NC];
  logic a_wr_en [NC];
  logic [31:0] a_wr_row [NC];
  logic a_busy [NC];
  logic a_done [NC];
  logic [31:0] a_iter [NC];
  logic a_conv [NC];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic sample(input int c);
    a_rd_en[c]  = bus.rd_en;
    a_rd_row[c] = 32'(bus.rd_row);
    a_wr_en[c]  = bus.wr_en;
    a_wr_row[c] = 32'(bus.wr_row);
    a_busy[c]   = bus.busy;
    a_done[c]   = bus.done;
    a_iter[c]   = 32'(bus.iter);
    a_conv[c]   = bus.converged;
  endtask

  task automatic rec(input int maxi, input int ncyc,
                     input bit hold, input bit par6);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.max_iter = ITER_W'(maxi);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      sample(c);
      bus.start      = hold;
      bus.row_parity = par6 && bus.wr_en
                       && (bus.wr_row == ROW_W'(6));
    end
    bus.start      = 1'b0;
    bus.row_parity = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.done === 1'b1);
    end
    chk(nm, 32'(seen), 1);
    @(negedge clk);
  endtask

  function automatic bit in_rng(int c, int lo, int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  vec_t tv[$];

  initial begin
    int nwr;
    int ok;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.max_iter = '0;
    bus.row_parity = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_rd_row", 32'(bus.rd_row), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_row", 32'(bus.wr_row), 0);
    chk("rst_iter", 32'(bus.iter), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_conv", 32'(bus.converged), 0);
    rst = 1'b0;

    // Run A: three full iterations; -1 marks don't-care
    tv.push_back(vec_t'{1, 1, 0, 0, -1, 1, 0, 0});
    tv.push_back(vec_t'{4, 1, 3, 0, -1, 1, 0, 0});
    tv.push_back(vec_t'{5, 1, 4, 1, 0, 1, 0, 0});
    tv.push_back(vec_t'{8, 1, 7, 1, 3, 1, 0, 0});
    tv.push_back(vec_t'{9, 0, -1, 1, 4, 1, 0, 0});
    tv.push_back(vec_t'{12, 0, -1, 1, 7, 1, 0, 0});
    tv.push_back(vec_t'{13, 0, -1, 0, -1, 1, 0, 0});
    tv.push_back(vec_t'{14, 1, 0, 0, -1, 1, 0, 1});
    tv.push_back(vec_t'{18, 1, 4, 1, 0, 1, 0, 1});
    tv.push_back(vec_t'{26, 0, -1, 0, -1, 1, 0, 1});
    tv.push_back(vec_t'{27, 1, 0, 0, -1, 1, 0, 2});
    tv.push_back(vec_t'{38, 0, -1, 1, 7, 1, 0, 2});
    tv.push_back(vec_t'{39, 0, -1, 0, -1, 1, 0, 2});
    tv.push_back(vec_t'{40, 0, -1, 0, -1, 1, 1, 3});
    tv.push_back(vec_t'{41, 0, -1, 0, -1, 0, 0, 3});

    rec(3, 45, 1'b0, 1'b1);
    foreach (tv[k]) begin
      int c;
      c = tv[k].c;
      chk($sformatf("A%0d_rd_en", c), 32'(a_rd_en[c]), tv[k].rd_en);
      if (tv[k].rd_row >= 0)
        chk($sformatf("A%0d_rd_row", c), a_rd_row[c], tv[k].rd_row);
      chk($sformatf("A%0d_wr_en", c), 32'(a_wr_en[c]), tv[k].wr_en);
      if (tv[k].wr_row >= 0)
        chk($sformatf("A%0d_wr_row", c), a_wr_row[c], tv[k].wr_row);
      chk($sformatf("A%0d_busy", c), 32'(a_busy[c]), tv[k].busy);
      chk($sformatf("A%0d_done", c), 32'(a_done[c]), tv[k].done);
      chk($sformatf("A%0d_iter", c), a_iter[c], tv[k].iter);
    end
    for (int c = 1; c <= 45; c++) begin
      chk($sformatf("A%0d_rd_en_t", c), 32'(a_rd_en[c]),
          32'(in_rng(c, 1, 8) || in_rng(c, 14, 21)
              || in_rng(c, 27, 34)));
      chk($sformatf("A%0d_wr_en_t", c), 32'(a_wr_en[c]),
          32'(in_rng(c, 5, 12) || in_rng(c, 18, 25)
              || in_rng(c, 31, 38)));
      chk($sformatf("A%0d_busy_t", c), 32'(a_busy[c]),
          32'(in_rng(c, 1, 40)));
      chk($sformatf("A%0d_done_t", c), 32'(a_done[c]),
          32'(c == 40));
    end
    nwr = 0;
    ok  = 1;
    for (int c = 5; c <= 45; c++) begin
      if (a_wr_en[c] === 1'b1) begin
        nwr++;
        if (a_rd_en[c-LAT] !== 1'b1
            || a_wr_row[c] !== a_rd_row[c-LAT]) ok = 0;
      end
    end
    chk("A_wr_count", nwr, 24);
    chk("A_wr_row_match", ok, 1);
    chk("A_conv", 32'(a_conv[41]), 0);

    // Run B: max_iter = 0 behaves as 1
    rec(0, 16, 1'b0, 1'b0);
    chk("B_done13", 32'(a_done[13]), 0);
    chk("B_iter13", a_iter[13], 0);
    chk("B_done14", 32'(a_done[14]), 1);
    chk("B_iter14", a_iter[14], 1);
    chk("B_busy15", 32'(a_busy[15]), 0);

    // Run C: reset in cycle 10, restart in cycle 12
    @(negedge clk);
    bus.start    = 1'b1;
    bus.max_iter = ITER_W'(3);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      sample(c);
      bus.start = (c == 12);
      rst       = (c == 10);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    chk("C10_wr_en", 32'(a_wr_en[10]), 1);
    chk("C10_wr_row", a_wr_row[10], 5);
    chk("C11_busy", 32'(a_busy[11]), 0);
    chk("C11_rd_en", 32'(a_rd_en[11]), 0);
    chk("C11_rd_row", a_rd_row[11], 0);
    chk("C11_wr_en", 32'(a_wr_en[11]), 0);
    chk("C11_wr_row", a_wr_row[11], 0);
    chk("C11_iter", a_iter[11], 0);
    chk("C11_done", 32'(a_done[11]), 0);
    chk("C11_conv", 32'(a_conv[11]), 0);
    chk("C12_wr_en", 32'(a_wr_en[12]), 0);
    chk("C12_rd_en", 32'(a_rd_en[12]), 0);
    chk("C13_rd_en", 32'(a_rd_en[13]), 1);
    chk("C13_rd_row", a_rd_row[13], 0);
    chk("C13_busy", 32'(a_busy[13]), 1);
    chk("C16_wr_en", 32'(a_wr_en[16]), 0);
    chk("C17_wr_en", 32'(a_wr_en[17]), 1);
    chk("C17_wr_row", a_wr_row[17], 0);
    wait_done("C_done_seen");

    // Run D: start held through decode and DONE cycle
    rec(1, 16, 1'b1, 1'b0);
    for (int c = 9; c <= 13; c++)
      chk($sformatf("D%0d_rd_en", c), 32'(a_rd_en[c]), 0);
    chk("D14_done", 32'(a_done[14]), 1);
    chk("D14_busy", 32'(a_busy[14]), 1);
    chk("D15_busy", 32'(a_busy[15]), 0);
    chk("D15_rd_en", 32'(a_rd_en[15]), 0);
    chk("D15_iter", a_iter[15], 1);
    chk("D16_rd_en", 32'(a_rd_en[16]), 1);
    chk("D16_rd_row", a_rd_row[16], 0);
    chk("D16_iter", a_iter[16], 0);
    wait_done("D_done_seen");

`ifdef LDPC_EARLY_TERM_EN
    // E1: clean syndrome on first pass
    rec(5, 16, 1'b0, 1'b0);
    chk("E1_conv1", 32'(a_conv[1]), 0);
    chk("E1_done13", 32'(a_done[13]), 0);
    chk("E1_done14", 32'(a_done[14]), 1);
    chk("E1_iter14", a_iter[14], 1);
    chk("E1_conv14", 32'(a_conv[14]), 1);
    chk("E1_rd_en14", 32'(a_rd_en[14]), 0);
    // E2: row 6 fails every pass
    rec(5, 70, 1'b0, 1'b1);
    chk("E2_done14", 32'(a_done[14]), 0);
    chk("E2_done66", 32'(a_done[66]), 1);
    chk("E2_iter67", a_iter[67], 5);
    chk("E2_conv67", 32'(a_conv[67]), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
